// File: rtl/intersection_scheduler_pkg.sv
// Shared definitions for the intersection phase scheduler.
//   - Lamp encodings for the 3-bit {red,yellow,green} lamp buses.
//   - Phase (state) codes, also exported on the debug phase output.
//   - A Moore decode from phase to lamp pattern.
package intersection_scheduler_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    HWY_G  = 3'd0,
    HWY_Y  = 3'd1,
    AR_A   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    PED_W  = 3'd5,
    AR_B   = 3'd6
  } phase_e;

  typedef struct packed {
    logic [2:0] hwy;
    logic [2:0] side;
    logic       walk;
  } lamps_t;

  // Anything that is not an explicit green/yellow phase shows red on both
  // roads, so an unexpected code can never produce a conflicting green.
  function automatic lamps_t decode_lamps(phase_e s);
    lamps_t l;
    l.hwy  = LAMP_RED;
    l.side = LAMP_RED;
    l.walk = 1'b0;
    case (s)
      HWY_G:   l.hwy  = LAMP_GRN;
      HWY_Y:   l.hwy  = LAMP_YEL;
      SIDE_G:  l.side = LAMP_GRN;
      SIDE_Y:  l.side = LAMP_YEL;
      PED_W:   l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Phase timer: CW-bit cycle counter for the current phase.
// Ports:
//   clock, reset : clock and synchronous active-high reset (count -> 0)
//   clr_i        : clear to 0 (phase change), overrides increment
//   inc_i        : increment by one
//   sat_i        : hold the count once it equals limit_i
//   limit_i      : terminal count for the current phase
//   cnt_o        : current count
//   done_o       : cnt_o == limit_i
module intersection_scheduler_phase_timer #(
  parameter int CW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          sat_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] cnt_o,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_limit;

  assign at_limit = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(sat_i && at_limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = at_limit;

endmodule

// File: rtl/intersection_scheduler.sv
// Intersection phase scheduler: highway default green, side-road car and
// pedestrian minor phases, with yellow and all-red clearance between greens.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   side_req     : side-road car present (level)
//   ped_req      : pedestrian button (pulse or level)
//   hwy          : highway lamps {red,yellow,green}
//   normal       : side-road lamps {red,yellow,green}
//   walk         : pedestrian walk lamp
//   phase        : current phase code (debug)
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 6,
  parameter int CW        = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] hwy,
  output logic [2:0] normal,
  output logic       walk,
  output logic [2:0] phase
);

  // Terminal counts: a phase of duration D leaves on the edge where cnt == D-1.
  localparam logic [CW-1:0] MIN_LIM  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LIM  = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_LIM  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_LIM   = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] WALK_LIM = CW'(WALK - 1);

  phase_e        state_q, state_d;
  logic          side_pend_q, side_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          rr_q, rr_d;           // 0: side preferred, 1: pedestrian preferred
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;
  logic          done;
  logic          phase_change;
  logic          enter_side;
  logic          enter_ped;
  lamps_t        lamps;

  intersection_scheduler_phase_timer #(
    .CW (CW)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (phase_change),
    .inc_i   (1'b1),
    .sat_i   (state_q == HWY_G),   // highway green may hold indefinitely
    .limit_i (limit),
    .cnt_o   (cnt),
    .done_o  (done)
  );

  // Next-phase logic
  always_comb begin
    state_d = state_q;
    limit   = '0;
    case (state_q)
      HWY_G: begin
        limit = MIN_LIM;
        if (done && (side_pend_q || ped_pend_q)) state_d = HWY_Y;
      end
      HWY_Y: begin
        limit = YEL_LIM;
        if (done) state_d = AR_A;
      end
      AR_A: begin
        limit = AR_LIM;
        if (done) begin
          // Round-robin only matters when both minor requests are waiting.
          if (side_pend_q && (!ped_pend_q || !rr_q)) state_d = SIDE_G;
          else                                       state_d = PED_W;
        end
      end
      SIDE_G: begin
        // Timer limit is the max-green cutoff; the min-green gap-out is a
        // separate compare so a held request extends green up to MAX_GREEN.
        limit = MAX_LIM;
        if (done || ((cnt >= MIN_LIM) && !side_req)) state_d = SIDE_Y;
      end
      SIDE_Y: begin
        limit = YEL_LIM;
        if (done) state_d = AR_B;
      end
      PED_W: begin
        limit = WALK_LIM;
        if (done) state_d = AR_B;
      end
      AR_B: begin
        limit = AR_LIM;
        if (done) state_d = HWY_G;
      end
      default: begin
        state_d = HWY_G;
      end
    endcase
  end

  assign phase_change = (state_d != state_q);
  assign enter_side   = (state_d == SIDE_G) && (state_q != SIDE_G);
  assign enter_ped    = (state_d == PED_W) && (state_q != PED_W);

  // Pending requests: clearing on service entry takes priority over a new set.
  always_comb begin
    side_pend_d = side_pend_q;
    ped_pend_d  = ped_pend_q;
    rr_d        = rr_q;

    if (enter_side) begin
      side_pend_d = 1'b0;
    end else if (side_req && (state_q != SIDE_G) && (state_q != SIDE_Y)) begin
      side_pend_d = 1'b1;
    end

    if (enter_ped) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && (state_q != PED_W)) begin
      ped_pend_d = 1'b1;
    end

    if (enter_side)     rr_d = 1'b1;
    else if (enter_ped) rr_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HWY_G;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      rr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      rr_q        <= rr_d;
    end
  end

  // Moore outputs from the registered phase
  assign lamps  = decode_lamps(state_q);
  assign hwy    = lamps.hwy;
  assign normal = lamps.side;
  assign walk   = lamps.walk;
  assign phase  = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler. Cycle c is the clock period
// after edge c-1, where edge -1 is the last edge sampled with reset high;
// inputs driven in cycle c are sampled at the end of cycle c.
module tb_intersection_scheduler;

  logic       clock;
  logic       reset;
  logic       side_req;
  logic       ped_req;
  logic [2:0] hwy;
  logic [2:0] normal;
  logic       walk;
  logic [2:0] phase;

  int checks;
  int failures;

  intersection_scheduler dut (
    .clock    (clock),
    .reset    (reset),
    .side_req (side_req),
    .ped_req  (ped_req),
    .hwy      (hwy),
    .normal   (normal),
    .walk     (walk),
    .phase    (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {phase, hwy, normal, walk} for a phase code, written from the
  // lamp table directly.
  function automatic logic [9:0] exp_out(int ph);
    case (ph)
      0:       return {3'd0, 3'b001, 3'b100, 1'b0};
      1:       return {3'd1, 3'b010, 3'b100, 1'b0};
      2:       return {3'd2, 3'b100, 3'b100, 1'b0};
      3:       return {3'd3, 3'b100, 3'b001, 1'b0};
      4:       return {3'd4, 3'b100, 3'b010, 1'b0};
      5:       return {3'd5, 3'b100, 3'b100, 1'b1};
      default: return {3'd6, 3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0.
  task automatic apply_reset();
    side_req = 1'b0;
    ped_req  = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    apply_reset();
    obs = {phase, hwy, normal, walk};
    checks++;
    if (obs !== exp_out(0)) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", obs, exp_out(0));
    end
    $display("test_reset: done");
  endtask

  task automatic test_idle();
    logic [9:0] obs;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      obs = {phase, hwy, normal, walk};
      checks++;
      if (obs !== exp_out(0)) begin
        failures++;
        $display("FAIL idle cycle=%0d got=%b want=%b", c, obs, exp_out(0));
      end
      tick();
    end
    $display("test_idle: 40 cycles");
  endtask

  task automatic test_side_pulse();
    logic [9:0] obs;
    int ep;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      side_req = (c == 2);
      if (c <= 7)       ep = 0;
      else if (c <= 10) ep = 1;
      else if (c <= 12) ep = 2;
      else if (c <= 20) ep = 3;
      else if (c <= 23) ep = 4;
      else if (c <= 25) ep = 6;
      else              ep = 0;
      obs = {phase, hwy, normal, walk};
      checks++;
      if (obs !== exp_out(ep)) begin
        failures++;
        $display("FAIL side_pulse cycle=%0d got=%b want=%b", c, obs, exp_out(ep));
      end
      tick();
    end
    side_req = 1'b0;
    $display("test_side_pulse: 40 cycles");
  endtask

  task automatic test_side_held();
    logic [9:0] obs;
    int ep;
    apply_reset();
    for (int c = 0; c < 52; c++) begin
      side_req = (c >= 2);
      if (c <= 7)       ep = 0;
      else if (c <= 10) ep = 1;
      else if (c <= 12) ep = 2;
      else if (c <= 28) ep = 3;   // max green cutoff
      else if (c <= 31) ep = 4;
      else if (c <= 33) ep = 6;   // request re-latched here
      else if (c <= 41) ep = 0;
      else if (c <= 44) ep = 1;
      else if (c <= 46) ep = 2;
      else              ep = 3;
      obs = {phase, hwy, normal, walk};
      checks++;
      if (obs !== exp_out(ep)) begin
        failures++;
        $display("FAIL side_held cycle=%0d got=%b want=%b", c, obs, exp_out(ep));
      end
      tick();
    end
    side_req = 1'b0;
    $display("test_side_held: 52 cycles");
  endtask

  task automatic test_both_requests();
    logic [9:0] obs;
    int ep;
    apply_reset();
    for (int c = 0; c < 62; c++) begin
      side_req = (c == 2);
      ped_req  = (c == 2);
      if (c <= 7)       ep = 0;
      else if (c <= 10) ep = 1;
      else if (c <= 12) ep = 2;
      else if (c <= 20) ep = 3;   // side first
      else if (c <= 23) ep = 4;
      else if (c <= 25) ep = 6;
      else if (c <= 33) ep = 0;   // highway returns for min green
      else if (c <= 36) ep = 1;
      else if (c <= 38) ep = 2;
      else if (c <= 44) ep = 5;   // walk
      else if (c <= 46) ep = 6;
      else              ep = 0;
      obs = {phase, hwy, normal, walk};
      checks++;
      if (obs !== exp_out(ep)) begin
        failures++;
        $display("FAIL both_req cycle=%0d got=%b want=%b", c, obs, exp_out(ep));
      end
      tick();
    end
    side_req = 1'b0;
    ped_req  = 1'b0;
    $display("test_both_requests: 62 cycles");
  endtask

  task automatic test_ped_during_walk();
    logic [9:0] obs;
    int ep;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      ped_req = (c == 2) || (c == 15);   // second press lands inside walk
      if (c <= 7)       ep = 0;
      else if (c <= 10) ep = 1;
      else if (c <= 12) ep = 2;
      else if (c <= 18) ep = 5;
      else if (c <= 20) ep = 6;
      else              ep = 0;
      obs = {phase, hwy, normal, walk};
      checks++;
      if (obs !== exp_out(ep)) begin
        failures++;
        $display("FAIL ped_in_walk cycle=%0d got=%b want=%b", c, obs, exp_out(ep));
      end
      tick();
    end
    ped_req = 1'b0;
    $display("test_ped_during_walk: 60 cycles");
  endtask

  task automatic test_reset_mid_side();
    logic [9:0] obs;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      side_req = (c == 2);
      tick();
    end
    side_req = 1'b0;
    obs = {phase, hwy, normal, walk};
    checks++;
    if (obs !== exp_out(3)) begin
      failures++;
      $display("FAIL mid_side_before_reset got=%b want=%b", obs, exp_out(3));
    end
    reset = 1'b1;
    tick();
    obs = {phase, hwy, normal, walk};
    checks++;
    if (obs !== exp_out(0)) begin
      failures++;
      $display("FAIL mid_reset_state got=%b want=%b", obs, exp_out(0));
    end
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      obs = {phase, hwy, normal, walk};
      checks++;
      if (obs !== exp_out(0)) begin
        failures++;
        $display("FAIL after_mid_reset cycle=%0d got=%b want=%b", c, obs, exp_out(0));
      end
      tick();
    end
    $display("test_reset_mid_side: done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    reset    = 1'b1;
    test_reset();
    test_idle();
    test_side_pulse();
    test_side_held();
    test_both_requests();
    test_ped_during_walk();
    test_reset_mid_side();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
